xyz_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one 3-entry, 5-bit register bank (x, y, z) among NREQ requesters. A three-state FSM grants one requester at a time and enforces a hold limit. The winner's write commands are muxed into the bank through a registered path. It sits between the requester FSMs and the x/y/z datapath, and is the only writer of that bank.

---
 rtl/xyz_bank_arbiter_pkg.sv | 24 ++
 rtl/xyz_bank_arbiter_if.sv | 34 +++
 rtl/xyz_bank_arbiter_rr_pick.sv | 30 +++
 rtl/xyz_bank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_xyz_bank_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/xyz_bank_arbiter_pkg.sv
// Shared types and constants for the x/y/z bank arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xyz_bank_pkg;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Register select encoding carried on each requester's sel lane
  localparam logic [1:0] SEL_X   = 2'd0;
  localparam logic [1:0] SEL_Y   = 2'd1;
  localparam logic [1:0] SEL_Z   = 2'd2;
  localparam logic [1:0] SEL_NOP = 2'd3;

  // Bank contents after reset
  localparam int X_RST = 1;
  localparam int Y_RST = 2;
  localparam int Z_RST = 3;

endpackage

// File: rtl/xyz_bank_arbiter_if.sv
// Requester-side bundle: per-requester req/done/we/sel/wdata in, grant/status/bank out.
// Latency: n/a (wires only).
// Backpressure: none; grant is the only flow control a requester sees.
interface xyz_bank_arbiter_if #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 3
);
  import xyz_bank_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       we;
  logic [2*NREQ-1:0]     sel;
  logic [WIDTH*NREQ-1:0] wdata;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  timeout;
  logic [WIDTH-1:0]      x;
  logic [WIDTH-1:0]      y;
  logic [WIDTH-1:0]      z;

  // Requester side drives requests and writes, observes grant and bank
  modport master (
    output req, done, we, sel, wdata,
    input  grant, busy, timeout, x, y, z
  );

  // Arbiter side
  modport slave (
    input  req, done, we, sel, wdata,
    output grant, busy, timeout, x, y, z
  );

endinterface

// File: rtl/xyz_bank_arbiter_rr_pick.sv
// Cyclic priority encoder: first set req bit at or after ptr, wrapping at NREQ.
// Latency: combinational.
// Backpressure: none; valid low when no request is set.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] cand;

  // Scan from farthest to nearest so the nearest set bit after ptr is the last writer
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/xyz_bank_arbiter.sv
// Round-robin owner of the x/y/z bank; the granted requester's writes land one cycle after capture.
// Latency: grant 1 cycle after req in IDLE; write visible 2 cycles after we; 1 dead DRAIN cycle per grant.
// Backpressure: non-granted requesters simply wait; ownership is revoked after HOLD_MAX cycles.
module xyz_bank_arbiter
  import xyz_bank_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int NREQ     = 3,
  parameter int HOLD_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  xyz_bank_arbiter_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HCW = $clog2(HOLD_MAX + 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [HCW-1:0]    hold_q, hold_d;
  logic              timeout_q, timeout_d;

  // Pending write captured from the owner, retired into the bank next cycle
  logic              pend_vld_q, pend_vld_d;
  logic [1:0]        pend_sel_q, pend_sel_d;
  logic [WIDTH-1:0]  pend_dat_q, pend_dat_d;

  logic [WIDTH-1:0]  x_q, y_q, z_q;

  logic              pick_vld;
  logic [IDW-1:0]    pick_idx;

  logic              own_req;
  logic              own_done;
  logic              own_we;
  logic [1:0]        own_sel;
  logic [WIDTH-1:0]  own_dat;
  logic              hold_hit;
  logic [IDW-1:0]    ptr_next;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Only the current owner's lane is ever looked at; other strobes are dropped here
  assign own_req  = bus.req[gnt_id_q];
  assign own_done = bus.done[gnt_id_q];
  assign own_we   = bus.we[gnt_id_q];
  assign own_sel  = bus.sel[2*gnt_id_q +: 2];
  assign own_dat  = bus.wdata[WIDTH*gnt_id_q +: WIDTH];

  assign hold_hit = (hold_q == HCW'(HOLD_MAX - 1));
  assign ptr_next = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

  // Next-state and next-register values for the grant FSM and write capture
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    pend_vld_d = 1'b0;
    pend_sel_d = pend_sel_q;
    pend_dat_d = pend_dat_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d  = OWN;
          gnt_id_d = pick_idx;
          grant_d  = NREQ'(1) << pick_idx;
          hold_d   = '0;
        end
      end

      OWN: begin
        hold_d = hold_q + HCW'(1);
        // Capture stays live on the release cycle so a last write still lands in DRAIN
        if (own_we) begin
          pend_vld_d = 1'b1;
          pend_sel_d = own_sel;
          pend_dat_d = own_dat;
        end
        if (own_done || !own_req || hold_hit) begin
          state_d   = DRAIN;
          grant_d   = '0;
          ptr_d     = ptr_next;
          // A done coinciding with the hold limit is a clean release, not a revoke
          timeout_d = hold_hit && !own_done;
        end
      end

      DRAIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // FSM, grant, pointer, hold counter and pending-write registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      timeout_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_sel_q <= SEL_NOP;
      pend_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
      pend_dat_q <= pend_dat_d;
    end
  end

  // Bank update: at most one register per cycle, from the pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= WIDTH'(X_RST);
      y_q <= WIDTH'(Y_RST);
      z_q <= WIDTH'(Z_RST);
    end else if (pend_vld_q) begin
      case (pend_sel_q)
        SEL_X:   x_q <= pend_dat_q;
        SEL_Y:   y_q <= pend_dat_q;
        SEL_Z:   z_q <= pend_dat_q;
        SEL_NOP: ;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.timeout = timeout_q;
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.z       = z_q;

endmodule

// File: tb/tb_xyz_bank_arbiter.sv
// Directed bench for xyz_bank_arbiter (WIDTH=5, NREQ=3, HOLD_MAX=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_xyz_bank_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  xyz_bank_arbiter_if #(.WIDTH(5), .NREQ(3)) bus ();

  xyz_bank_arbiter #(
    .WIDTH    (5),
    .NREQ     (3),
    .HOLD_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req   = '0;
    bus.done  = '0;
    bus.we    = '0;
    bus.sel   = '1;
    bus.wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  logic [2:0] rr_exp [4];

  initial begin
    tests = 0;
    fails = 0;
    rr_exp[0] = 3'b001;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    // Reset state and idling
    chk("rst_x", 32'(bus.x), 32'd1);
    chk("rst_y", 32'(bus.y), 32'd2);
    chk("rst_z", 32'(bus.z), 32'd3);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_grant", 32'(bus.grant), 32'd0);
    end
    chk("idle_x", 32'(bus.x), 32'd1);

    // Single write into y by requester 0
    bus.req = 3'b001;
    step();
    chk("sw_grant", 32'(bus.grant), 32'b001);
    chk("sw_busy", 32'(bus.busy), 32'd1);
    bus.we    = 3'b001;
    bus.sel   = 6'b11_11_01;
    bus.wdata = 15'd9;
    step();
    chk("sw_y_not_yet", 32'(bus.y), 32'd2);
    chk("sw_grant_hold", 32'(bus.grant), 32'b001);
    bus.we   = '0;
    bus.done = 3'b001;
    step();
    chk("sw_y", 32'(bus.y), 32'd9);
    chk("sw_grant_off", 32'(bus.grant), 32'd0);
    chk("sw_busy_drain", 32'(bus.busy), 32'd1);
    chk("sw_no_timeout", 32'(bus.timeout), 32'd0);
    bus.done = '0;
    bus.req  = '0;
    step();
    chk("sw_busy_off", 32'(bus.busy), 32'd0);

    // Round-robin with all requesters asking
    do_reset();
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", 32'(bus.grant), 32'(rr_exp[k]));
      bus.done = rr_exp[k];
      step();
      chk("rr_gap1", 32'(bus.grant), 32'd0);
      bus.done = '0;
      step();
      chk("rr_gap2", 32'(bus.grant), 32'd0);
    end
    bus.req = '0;
    step();

    // Forced revoke after HOLD_MAX cycles
    do_reset();
    bus.req = 3'b010;
    step();
    chk("to_grant0", 32'(bus.grant), 32'b010);
    chk("to_pulse_early", 32'(bus.timeout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_grant_held", 32'(bus.grant), 32'b010);
    end
    step();
    chk("to_grant_off", 32'(bus.grant), 32'd0);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    step();
    chk("to_pulse_once", 32'(bus.timeout), 32'd0);
    chk("to_busy_off", 32'(bus.busy), 32'd0);
    bus.req = 3'b111;
    step();
    chk("to_ptr2", 32'(bus.grant), 32'b100);
    bus.done = 3'b100;
    step();
    bus.done = '0;
    bus.req  = '0;
    step();

    // Strobes from a non-granted requester are ignored
    bus.req = 3'b001;
    step();
    chk("ig_grant", 32'(bus.grant), 32'b001);
    bus.we    = 3'b100;
    bus.sel   = 6'b00_11_11;
    bus.wdata = 15'd31 << 10;
    bus.done  = 3'b100;
    step();
    chk("ig_grant_kept", 32'(bus.grant), 32'b001);
    step();
    chk("ig_x", 32'(bus.x), 32'd1);
    chk("ig_grant_kept2", 32'(bus.grant), 32'b001);
    idle_inputs();
    bus.req  = 3'b001;
    bus.done = 3'b001;
    step();
    idle_inputs();
    step();

    // Done together with the hold limit: clean release, no timeout
    bus.req = 3'b010;
    step();
    chk("dh_grant", 32'(bus.grant), 32'b010);
    step();
    step();
    step();
    chk("dh_grant_held", 32'(bus.grant), 32'b010);
    bus.done = 3'b010;
    step();
    chk("dh_grant_off", 32'(bus.grant), 32'd0);
    chk("dh_no_timeout", 32'(bus.timeout), 32'd0);
    idle_inputs();
    step();

    // Reset discards a pending write
    bus.req = 3'b100;
    step();
    chk("rw_grant", 32'(bus.grant), 32'b100);
    bus.we    = 3'b100;
    bus.sel   = 6'b10_11_11;
    bus.wdata = 15'd7 << 10;
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    chk("rw_z_rst", 32'(bus.z), 32'd3);
    chk("rw_grant_rst", 32'(bus.grant), 32'd0);
    chk("rw_busy_rst", 32'(bus.busy), 32'd0);
    step();
    chk("rw_z_after", 32'(bus.z), 32'd3);
    chk("rw_x_after", 32'(bus.x), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
